// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared definitions for the data-memory responder. Holds the
//               load/store flag bit positions (the core indexes its flag
//               vectors with these same constants), the responder FSM state
//               encoding and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int XLEN = 32;

    // Bit positions inside the one-hot load flag vector
    localparam int LD_FLAG_W = 5;
    localparam int LD_LB     = 0;
    localparam int LD_LH     = 1;
    localparam int LD_LW     = 2;
    localparam int LD_LBU    = 3;
    localparam int LD_LHU    = 4;

    // Bit positions inside the one-hot store flag vector
    localparam int ST_FLAG_W = 3;
    localparam int ST_SB     = 0;
    localparam int ST_SH     = 1;
    localparam int ST_SW     = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Number of set bits across the concatenated load and store flags.
    function automatic logic [3:0] flag_count(input logic [7:0] flags);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, flags[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bytelane_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytelane_ram
// Description : Single-port DEPTH_WORDS x 32 data RAM built from four byte
//               lanes, each with its own write enable. Read is synchronous
//               and read-first; contents are never reset.
// Ports       : clk_i   - clock
//               en_i    - access enable (read, plus write on enabled lanes)
//               we_i    - per-byte-lane write enables
//               addr_i  - word index
//               wdata_i - lane-aligned write data
//               rdata_o - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bytelane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    import dmem_responder_pkg::*;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (en_i) begin
                if (we_i[i]) begin
                    mem_q[addr_i] <= wdata_i[8*i +: 8];
                end
                rd_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[8*i +: 8] = rd_q;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Slave end of the core's load/store interface. Accepts one
//               request at a time, waits WAIT_CYCLES cycles, then commits a
//               store or returns sign/zero-extended load data. XLEN must be 32.
// Ports       : clk, rst                  - clock, sync active-high reset
//               req_valid / req_ready     - request handshake
//               req_addr                  - byte address
//               req_load_flag             - one-hot LB/LH/LW/LBU/LHU
//               req_store_flag            - one-hot SB/SH/SW
//               req_wdata                 - right-aligned store data
//               rsp_valid / rsp_ready     - response handshake
//               rsp_rdata                 - extended load data (0 otherwise)
//               rsp_err                   - access rejected
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int XLEN        = dmem_responder_pkg::XLEN,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [4:0]      req_load_flag,
    input  logic [2:0]      req_store_flag,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    import dmem_responder_pkg::*;

    localparam int              AW           = $clog2(DEPTH_WORDS);
    localparam bit              C_ZERO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]      C_WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [XLEN-1:0] C_ADDR_LIMIT = XLEN'(4 * DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [4:0]      ld_q;
    logic [2:0]      st_q;
    logic            err_q;

    logic            w_accept, w_live, w_exec, w_err;
    logic [XLEN-1:0] w_addr, w_wdata, w_wdata_lane;
    logic [4:0]      w_ld;
    logic [2:0]      w_st;
    logic            w_is_half, w_is_word;
    logic [3:0]      w_be, w_ram_we;
    logic            w_ram_en;
    logic [31:0]     w_rd;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ext;

    assign w_accept = (state_q == S_IDLE) & req_valid;

    // With zero wait states the access executes on the accept edge itself,
    // so the RAM and error logic must look at the live request rather than
    // the (not yet loaded) latched copy.
    assign w_live  = C_ZERO_WAIT & (state_q == S_IDLE);
    assign w_addr  = w_live ? req_addr       : addr_q;
    assign w_wdata = w_live ? req_wdata      : wdata_q;
    assign w_ld    = w_live ? req_load_flag  : ld_q;
    assign w_st    = w_live ? req_store_flag : st_q;

    assign w_exec = ((state_q == S_WAIT) && (cnt_q == 4'd0)) || (C_ZERO_WAIT && w_accept);

    assign w_is_half = w_ld[LD_LH] | w_ld[LD_LHU] | w_st[ST_SH];
    assign w_is_word = w_ld[LD_LW] | w_st[ST_SW];
    assign w_err     = (flag_count({w_ld, w_st}) > 4'd1)
                     | (w_is_half & w_addr[0])
                     | (w_is_word & (w_addr[1:0] != 2'b00))
                     | (w_addr >= C_ADDR_LIMIT);

    // Replicate store data across lanes; byte enables pick the live lanes.
    always_comb begin
        w_be         = 4'b0000;
        w_wdata_lane = w_wdata;
        if (w_st[ST_SB]) begin
            w_be         = 4'b0001 << w_addr[1:0];
            w_wdata_lane = {4{w_wdata[7:0]}};
        end else if (w_st[ST_SH]) begin
            w_be         = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{w_wdata[15:0]}};
        end else if (w_st[ST_SW]) begin
            w_be         = 4'b1111;
        end
    end

    // Reset wins over a commit landing on the same edge.
    assign w_ram_en = w_exec & ~rst;
    assign w_ram_we = (w_ram_en & ~w_err) ? w_be : 4'b0000;

    dmem_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (w_ram_en),
        .we_i    (w_ram_we),
        .addr_i  (w_addr[AW+1:2]),
        .wdata_i (w_wdata_lane),
        .rdata_o (w_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                ld_q    <= req_load_flag;
                st_q    <= req_store_flag;
            end
            if (w_exec) begin
                err_q <= w_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (C_ZERO_WAIT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load extension works from the RAM's registered output and the latched
    // address, both of which are stable for the whole RESP phase.
    assign w_half = addr_q[1] ? w_rd[31:16] : w_rd[15:0];

    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_byte = w_rd[7:0];
            2'd1:    w_byte = w_rd[15:8];
            2'd2:    w_byte = w_rd[23:16];
            default: w_byte = w_rd[31:24];
        endcase
    end

    always_comb begin
        w_ext = '0;
        if (ld_q[LD_LB])       w_ext = {{24{w_byte[7]}}, w_byte};
        else if (ld_q[LD_LH])  w_ext = {{16{w_half[15]}}, w_half};
        else if (ld_q[LD_LW])  w_ext = w_rd;
        else if (ld_q[LD_LBU]) w_ext = {24'd0, w_byte};
        else if (ld_q[LD_LHU]) w_ext = {16'd0, w_half};
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !err_q) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder (WAIT_CYCLES = 1).
//               Directed accesses push their expected response into a
//               scoreboard; an independent monitor pops and compares on
//               every response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 1;

    localparam logic [4:0] F_LB  = 5'(1 << LD_LB);
    localparam logic [4:0] F_LH  = 5'(1 << LD_LH);
    localparam logic [4:0] F_LW  = 5'(1 << LD_LW);
    localparam logic [4:0] F_LBU = 5'(1 << LD_LBU);
    localparam logic [4:0] F_LHU = 5'(1 << LD_LHU);
    localparam logic [2:0] F_SB  = 3'(1 << ST_SB);
    localparam logic [2:0] F_SH  = 3'(1 << ST_SH);
    localparam logic [2:0] F_SW  = 3'(1 << ST_SW);

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_load_flag;
    logic [2:0]  req_store_flag;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    dmem_responder #(
        .XLEN        (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_load_flag  (req_load_flag),
        .req_store_flag (req_store_flag),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({nm, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
    endtask

    // Monitor: compares every taken response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    // One access; hold > 0 keeps rsp_ready low for that many response cycles.
    task automatic access(input logic [4:0] ld, input logic [2:0] st,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input string nm, input int hold);
        exp_t ent;
        int   lat;
        bit   seen;
        ent.rdata = exp_rd;
        ent.err   = exp_err;
        ent.name  = nm;
        sb_q.push_back(ent);

        @(posedge clk); #1;
        req_valid      = 1'b1;
        req_addr       = addr;
        req_wdata      = wdata;
        req_load_flag  = ld;
        req_store_flag = st;
        if (hold > 0) rsp_ready = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no req_ready in 20 cycles, expected accept", nm);
            req_valid = 1'b0;
            return;
        end

        @(posedge clk); #1;
        req_valid      = 1'b0;
        req_load_flag  = 5'd0;
        req_store_flag = 3'd0;

        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        check({nm, "_latency"}, 32'(lat), 32'(WAIT + 1));

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                check({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({nm, "_hold_rdata"}, rsp_rdata, exp_rd);
                check({nm, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({nm, "_release_req_ready"}, {31'd0, req_ready}, 32'd1);
            check({nm, "_release_valid"}, {31'd0, rsp_valid}, 32'd0);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (!rsp_valid) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL %s_complete: got rsp_valid stuck high, expected response taken", nm);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by time limit, expected summary");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = 32'd0;
        req_wdata      = 32'd0;
        req_load_flag  = 5'd0;
        req_store_flag = 3'd0;
        rsp_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Word store/load and extension
        access(5'd0, F_SW, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw_10",   0);
        access(F_LW, 3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10",   0);
        access(F_LB, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb_13",   0);
        access(F_LBU,3'd0, 32'h13, 32'h0,        32'h000000DE, 1'b0, "lbu_13",  0);
        access(F_LH, 3'd0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_10",   0);
        access(F_LHU,3'd0, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, "lhu_12",  0);

        // Byte-lane store
        access(5'd0, F_SB, 32'h11, 32'h12345677, 32'h0,        1'b0, "sb_11",   0);
        access(F_LW, 3'd0, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0, "lw_10_b", 0);

        // No-op
        access(5'd0, 3'd0, 32'h10, 32'h0,        32'h0,        1'b0, "noop",    0);

        // Error cases, each followed by a load proving memory untouched
        access(F_LW, 3'd0, 32'h12, 32'h0,        32'h0,        1'b1, "err_lw_12",   0);
        access(F_LW, 3'd0, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0, "lw_10_c",     0);
        access(5'd0, F_SW, 32'h20, 32'h11223344, 32'h0,        1'b0, "sw_20",       0);
        access(5'd0, F_SH, 32'h21, 32'h0000FFFF, 32'h0,        1'b1, "err_sh_21",   0);
        access(F_LW, 3'd0, 32'h20, 32'h0,        32'h11223344, 1'b0, "lw_20",       0);
        access(5'd0, F_SW, 32'h0,  32'hCAFEF00D, 32'h0,        1'b0, "sw_0",        0);
        access(5'd0, F_SW, 32'(4*DEPTH), 32'h55555555, 32'h0,  1'b1, "err_sw_range",0);
        access(F_LW, 3'd0, 32'h0,  32'h0,        32'hCAFEF00D, 1'b0, "lw_0",        0);
        access(F_LW | F_LB, 3'd0, 32'h10, 32'h0, 32'h0,        1'b1, "err_multi",   0);
        access(F_LW, 3'd0, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0, "lw_10_d",     0);

        // Backpressure
        access(F_LW, 3'd0, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0, "bp_lw_10",    5);

        // Reset during WAIT of a store: the store must be dropped
        access(5'd0, F_SW, 32'h40, 32'h0,        32'h0,        1'b0, "sw_40_zero",  0);
        @(posedge clk); #1;
        req_valid      = 1'b1;
        req_addr       = 32'h40;
        req_wdata      = 32'hAAAAAAAA;
        req_store_flag = F_SW;
        @(negedge clk);
        check("midrst_accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid      = 1'b0;
        req_store_flag = 3'd0;
        rst            = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        access(F_LW, 3'd0, 32'h40, 32'h0,        32'h0,        1'b0, "lw_40",       0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
